// File: rtl/wave_capture_mc_if.sv
// Capture-side bundle: codec strobe/sample, trigger controls, display idle in;
// sample-RAM write port and status out.
interface wave_capture_mc_if #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned IN_WIDTH     = 16,
  parameter int unsigned OUT_WIDTH    = 8,
  parameter int unsigned SAMPLES_LOG2 = 8
);
  localparam int unsigned CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned AW      = 1 + CH_BITS + SAMPLES_LOG2;

  logic                          new_sample;
  logic [CHANNELS*IN_WIDTH-1:0]  sample;
  logic [CH_BITS-1:0]            trig_channel;
  logic                          trig_falling;
  logic [OUT_WIDTH-1:0]          trig_level;
  logic                          wave_display_idle;
  logic                          write_enable;
  logic [AW-1:0]                 write_address;
  logic [OUT_WIDTH-1:0]          write_sample;
  logic                          read_index;
  logic                          armed;
  logic                          overrun;

  modport master (
    output new_sample, sample, trig_channel, trig_falling, trig_level, wave_display_idle,
    input  write_enable, write_address, write_sample, read_index, armed, overrun
  );

  modport slave (
    input  new_sample, sample, trig_channel, trig_falling, trig_level, wave_display_idle,
    output write_enable, write_address, write_sample, read_index, armed, overrun
  );
endinterface

// File: rtl/wave_capture_mc.sv
// Multi-channel triggered capture into the write half of a ping-pong sample RAM.
// One accepted strobe fans out into CHANNELS sequential RAM writes.
module wave_capture_mc #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned IN_WIDTH     = 16,
  parameter int unsigned OUT_WIDTH    = 8,
  parameter int unsigned SAMPLES_LOG2 = 8,
  parameter int unsigned AUTO_TIMEOUT = 1024
) (
  input logic              clk,
  input logic              reset,
  wave_capture_mc_if.slave cap
);
  localparam int unsigned CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned AW      = 1 + CH_BITS + SAMPLES_LOG2;
  localparam int unsigned AUTO_W  = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT + 1) : 1;

  localparam logic [OUT_WIDTH-1:0]    SignFlip = OUT_WIDTH'(1) << (OUT_WIDTH - 1);
  localparam logic [CH_BITS-1:0]      ChLast   = CH_BITS'(CHANNELS - 1);
  localparam logic [SAMPLES_LOG2-1:0] IdxLast  = '1;

  typedef enum logic [1:0] {StArmed, StActive, StWait} state_e;

  state_e state_q, state_d;

  logic [OUT_WIDTH-1:0]    conv_in [CHANNELS];
  logic [OUT_WIDTH-1:0]    conv_q  [CHANNELS];
  logic [OUT_WIDTH-1:0]    conv_d  [CHANNELS];
  logic [OUT_WIDTH-1:0]    prev_q, prev_d, cur;
  logic                    prev_valid_q, prev_valid_d;
  logic [AUTO_W-1:0]       auto_cnt_q, auto_cnt_d;
  logic [SAMPLES_LOG2:0]   index_q, index_d;
  logic [SAMPLES_LOG2-1:0] wr_idx_q, wr_idx_d;
  logic                    seq_active_q, seq_active_d;
  logic [CH_BITS-1:0]      ch_q, ch_d, trig_sel;
  logic                    read_index_q, read_index_d;
  logic                    we_q, we_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [OUT_WIDTH-1:0]    wsample_q, wsample_d;
  logic                    armed_q, armed_d;
  logic                    overrun_q, overrun_d;

  logic busy, full, accept, drop, edge_hit, auto_hit, trigger, start, last_issue, swap;

  // Only the top OUT_WIDTH bits of each channel are stored.
  logic [CHANNELS*IN_WIDTH-1:0] unused_sample;
  assign unused_sample = cap.sample;

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      conv_in[c] = cap.sample[c*IN_WIDTH + (IN_WIDTH - OUT_WIDTH) +: OUT_WIDTH] ^ SignFlip;
    end
  end

  assign trig_sel = (32'(cap.trig_channel) < CHANNELS) ? cap.trig_channel : '0;
  assign cur      = conv_in[trig_sel];

  // Busy only while channels 1..CHANNELS-1 are still to be issued.
  assign busy       = seq_active_q && (ch_q != ChLast);
  assign full       = index_q[SAMPLES_LOG2];
  assign accept     = cap.new_sample && !busy &&
                      ((state_q == StArmed) || ((state_q == StActive) && !full));
  assign drop       = cap.new_sample && busy;
  assign edge_hit   = prev_valid_q && (cap.trig_falling ?
                      ((prev_q >= cap.trig_level) && (cur < cap.trig_level)) :
                      ((prev_q < cap.trig_level) && (cur >= cap.trig_level)));
  assign auto_hit   = (AUTO_TIMEOUT != 0) && ((32'(auto_cnt_q) + 32'd1) == AUTO_TIMEOUT);
  assign trigger    = accept && (state_q == StArmed) && (edge_hit || auto_hit);
  assign start      = trigger || (accept && (state_q == StActive));
  assign last_issue = (state_q == StActive) && seq_active_q && (ch_q == ChLast) &&
                      (wr_idx_q == IdxLast);
  assign swap       = (state_q == StWait) && cap.wave_display_idle;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StArmed;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StArmed:  if (trigger)    state_d = StActive;
      StActive: if (last_issue) state_d = StWait;
      StWait:   if (swap)       state_d = StArmed;
      default:                  state_d = StArmed;
    endcase
  end

  always_comb begin
    conv_d       = conv_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    auto_cnt_d   = auto_cnt_q;
    index_d      = index_q;
    wr_idx_d     = wr_idx_q;
    seq_active_d = seq_active_q;
    ch_d         = ch_q;
    read_index_d = read_index_q;
    addr_d       = addr_q;
    wsample_d    = wsample_q;
    overrun_d    = overrun_q || drop;
    we_d         = seq_active_q;
    armed_d      = (state_d == StArmed);

    if (accept) conv_d = conv_in;
    if (accept && (state_q == StArmed)) begin
      prev_d       = cur;
      prev_valid_d = 1'b1;
      auto_cnt_d   = auto_cnt_q + 1'b1;
    end

    if (trigger) begin
      wr_idx_d = '0;
      index_d  = (SAMPLES_LOG2 + 1)'(1);
    end else if (accept && (state_q == StActive)) begin
      wr_idx_d = index_q[SAMPLES_LOG2-1:0];
      index_d  = index_q + 1'b1;
    end

    if (start) begin
      seq_active_d = 1'b1;
      ch_d         = '0;
    end else if (seq_active_q) begin
      if (ch_q == ChLast) seq_active_d = 1'b0;
      else                ch_d = ch_q + 1'b1;
    end

    if (seq_active_q) begin
      addr_d    = {~read_index_q, ch_q, wr_idx_q};
      wsample_d = conv_q[ch_q];
    end

    if (swap) begin
      read_index_d = ~read_index_q;
      prev_valid_d = 1'b0;
      auto_cnt_d   = '0;
      index_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < CHANNELS; c++) conv_q[c] <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      auto_cnt_q   <= '0;
      index_q      <= '0;
      wr_idx_q     <= '0;
      seq_active_q <= 1'b0;
      ch_q         <= '0;
      read_index_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wsample_q    <= '0;
      armed_q      <= 1'b1;
      overrun_q    <= 1'b0;
    end else begin
      conv_q       <= conv_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      auto_cnt_q   <= auto_cnt_d;
      index_q      <= index_d;
      wr_idx_q     <= wr_idx_d;
      seq_active_q <= seq_active_d;
      ch_q         <= ch_d;
      read_index_q <= read_index_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wsample_q    <= wsample_d;
      armed_q      <= armed_d;
      overrun_q    <= overrun_d;
    end
  end

  assign cap.write_enable  = we_q;
  assign cap.write_address = addr_q;
  assign cap.write_sample  = wsample_q;
  assign cap.read_index    = read_index_q;
  assign cap.armed         = armed_q;
  assign cap.overrun       = overrun_q;
endmodule

// File: tb/tb_wave_capture_mc.sv
// Randomised scoreboard bench for wave_capture_mc: a transaction-level model queues
// expected RAM writes (edge, address, byte); a negedge monitor pops and compares them.
module tb_wave_capture_mc;
  localparam int AUTO = 16;
  localparam int NSMP = 8;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  wave_capture_mc_if #(.CHANNELS(2), .IN_WIDTH(16), .OUT_WIDTH(8), .SAMPLES_LOG2(3)) bus ();

  wave_capture_mc #(
    .CHANNELS(2), .IN_WIDTH(16), .OUT_WIDTH(8), .SAMPLES_LOG2(3), .AUTO_TIMEOUT(AUTO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cap   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          edge_n;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t q[$];

  // Reference model: 0 = waiting for trigger, 1 = capturing, 2 = screen full
  int m_state, m_pv, m_prev, m_auto, m_idx, m_rd;
  logic exp_ovr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int conv(input logic [15:0] s);
    return (int'($signed(s)) + 32768) >> 8;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pv = 0; m_prev = 0; m_auto = 0; m_idx = 0; m_rd = 0;
    exp_ovr = 1'b0;
  endtask

  task automatic model_accept(input logic [15:0] s0, input logic [15:0] s1, input int t);
    int  b[2];
    int  cur, lvl;
    bit  fire;
    wr_t e;
    b[0] = conv(s0);
    b[1] = conv(s1);
    if (m_state == 2) return;
    if (m_state == 0) begin
      cur = b[int'(bus.trig_channel)];
      lvl = int'(bus.trig_level);
      m_auto++;
      fire = (m_auto == AUTO);
      if (m_pv != 0) begin
        if (bus.trig_falling) fire = fire || (m_prev >= lvl && cur < lvl);
        else                  fire = fire || (m_prev < lvl && cur >= lvl);
      end
      m_pv = 1;
      m_prev = cur;
      if (!fire) return;
      m_state = 1;
      m_idx = 0;
    end
    for (int c = 0; c < 2; c++) begin
      e.edge_n = t + 1 + c;
      e.addr   = 32'((1 - m_rd) * 16 + c * 8 + m_idx);
      e.data   = 32'(b[c]);
      q.push_back(e);
    end
    m_idx++;
    if (m_idx == NSMP) m_state = 2;
  endtask

  always @(negedge clk) begin
    while (q.size() != 0 && q[0].edge_n < cyc) begin
      chk("write_missing_edge", 32'(cyc), 32'(q[0].edge_n));
      void'(q.pop_front());
    end
    if (bus.write_enable === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0h data %0h, no write expected (cycle %0d)",
                 bus.write_address, bus.write_sample, cyc);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("write_edge", 32'(cyc), 32'(e.edge_n));
        chk("write_address", 32'(bus.write_address), e.addr);
        chk("write_sample", 32'(bus.write_sample), e.data);
      end
    end
  end

  task automatic strobe(input logic [15:0] s0, input logic [15:0] s1, input int gap);
    @(negedge clk);
    bus.new_sample = 1'b1;
    bus.sample     = {s1, s0};
    model_accept(s0, s1, cyc + 1);
    @(negedge clk);
    bus.new_sample = 1'b0;
    chk("armed", 32'(bus.armed), 32'(m_state == 0));
    chk("overrun", 32'(bus.overrun), 32'(exp_ovr));
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("pending_writes", 32'(q.size()), 32'd0);
  endtask

  task automatic swap();
    @(negedge clk);
    bus.wave_display_idle = 1'b1;
    @(negedge clk);
    bus.wave_display_idle = 1'b0;
    m_rd ^= 1;
    m_state = 0; m_pv = 0; m_auto = 0;
    chk("read_index_swap", 32'(bus.read_index), 32'(m_rd));
    chk("armed_after_swap", 32'(bus.armed), 32'd1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_write_enable", 32'(bus.write_enable), 32'd0);
    chk("rst_write_address", 32'(bus.write_address), 32'd0);
    chk("rst_write_sample", 32'(bus.write_sample), 32'd0);
    chk("rst_read_index", 32'(bus.read_index), 32'd0);
    chk("rst_armed", 32'(bus.armed), 32'd1);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
  endtask

  task automatic rand_strobe(input int gap);
    strobe(16'($urandom()), 16'($urandom()), gap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ovr_done;
    reset = 1'b1;
    bus.new_sample = 1'b0;
    bus.sample = '0;
    bus.trig_channel = 1'b0;
    bus.trig_falling = 1'b0;
    bus.trig_level = 8'h80;
    bus.wave_display_idle = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;

    // Rising edge on ch0 at level 0x80
    strobe(16'hF000, 16'h1234, 0);
    strobe(16'hF100, 16'h1234, 0);
    strobe(16'h0100, 16'h1234, 0);
    for (int k = 2; k <= 8; k++) strobe(16'(k << 8), 16'h1234, 1);
    drain();

    // Display busy: strobes in WAIT are ignored, no swap, no overrun
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.new_sample = 1'b1;
      bus.sample = $urandom();
    end
    @(negedge clk);
    bus.new_sample = 1'b0;
    chk("read_index_hold", 32'(bus.read_index), 32'(m_rd));
    chk("overrun_in_wait", 32'(bus.overrun), 32'(exp_ovr));
    chk("armed_in_wait", 32'(bus.armed), 32'd0);
    swap();

    // Falling edge on ch1 at level 0x40: only 0x41 -> 0x3F fires
    bus.trig_channel = 1'b1;
    bus.trig_falling = 1'b1;
    bus.trig_level = 8'h40;
    strobe(16'h0000, 16'h4000, 0);
    strobe(16'h0000, 16'h3F00, 0);
    strobe(16'h0000, 16'hC100, 0);
    strobe(16'h0000, 16'hBF00, 0);
    for (int k = 0; k < 7; k++) strobe(16'(k * 300), 16'(k * 4000), 0);
    drain();
    swap();

    // Auto trigger on a flat input
    bus.trig_channel = 1'b0;
    bus.trig_falling = 1'b0;
    bus.trig_level = 8'h80;
    n = 0;
    while (m_state != 2 && n < 40) begin
      strobe(16'h0000, 16'h0000, 0);
      n++;
    end
    drain();
    swap();

    // Random captures, with one back-to-back strobe pair in the middle of one
    ovr_done = 1'b0;
    for (int capn = 0; capn < 6; capn++) begin
      bus.trig_channel = 1'($urandom_range(0, 1));
      bus.trig_falling = 1'($urandom_range(0, 1));
      bus.trig_level = 8'($urandom());
      n = 0;
      while (m_state != 2 && n < 200) begin
        if (capn == 2 && !ovr_done && m_state == 1 && m_idx == 3) begin
          @(negedge clk);
          bus.new_sample = 1'b1;
          bus.sample = 32'h1111_2222;
          model_accept(16'h2222, 16'h1111, cyc + 1);
          @(negedge clk);
          bus.sample = 32'h3333_4444;
          @(negedge clk);
          bus.new_sample = 1'b0;
          exp_ovr = 1'b1;
          chk("overrun_set", 32'(bus.overrun), 32'(exp_ovr));
          ovr_done = 1'b1;
        end else begin
          rand_strobe($urandom_range(0, 2));
        end
        n++;
      end
      drain();
      swap();
    end

    // Reset in the middle of the write pair for index 3
    n = 0;
    while (!(m_state == 1 && m_idx == 4) && n < 200) begin
      rand_strobe(0);
      n++;
    end
    @(negedge clk);
    #1;
    q.delete();
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("no_writes_after_reset", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wave_capture_mc.md
# wave_capture_mc

Multi-channel, parametrised capture engine for the wave display path. It converts incoming signed audio samples to unsigned display bytes and arms on a configurable edge/level trigger on a selectable channel. After triggering it writes one screen's worth of samples per channel into the write half of a ping-pong sample RAM, then swaps banks when the display reports idle. It sits between the codec sample stream and the 1-write/2-read sample RAM, feeding `wave_display`. It generalises the single-channel capture with channel count, widths, auto-trigger and overrun detection.

## Interface
- `CHANNELS`, 2: number of captured channels (≥1).
- `IN_WIDTH`, 16: signed input sample width per channel.
- `OUT_WIDTH`, 8: stored sample width (≤ IN_WIDTH).
- `SAMPLES_LOG2`, 8: log2 samples per channel per bank.
- `AUTO_TIMEOUT`, 1024: accepted samples in ARMED before a forced trigger; 0 disables auto-trigger.
- Derived: `CH_BITS` = max(1, clog2(CHANNELS)); `AW` = 1 + CH_BITS + SAMPLES_LOG2.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `new_sample`  in  1  one-cycle strobe; `sample` valid.
- `sample`  in  CHANNELS*IN_WIDTH  channel c at bits [c*IN_WIDTH +: IN_WIDTH].
- `trig_channel`  in  CH_BITS  trigger source; values ≥ CHANNELS select channel 0.
- `trig_falling`  in  1  0 = rising edge, 1 = falling edge.
- `trig_level`  in  OUT_WIDTH  threshold, in converted (unsigned) units.
- `wave_display_idle`  in  1  display is not reading; bank swap permitted.
- `write_enable`  out  1  RAM write strobe.
- `write_address`  out  AW  {bank, channel, index}.
- `write_sample`  out  OUT_WIDTH  converted sample.
- `read_index`  out  1  bank the display reads; writes go to ~read_index.
- `armed`  out  1  high in ARMED.
- `overrun`  out  1  sticky; a strobe was dropped while the sequencer was busy.

## Operation
- Conversion: conv(s) = {~s[IN_WIDTH-1], s[IN_WIDTH-2 : IN_WIDTH-OUT_WIDTH]}, i.e. the top bits in offset binary. Signed 0 maps to 2^(OUT_WIDTH-1).
- Acceptance: a `new_sample` is accepted when the write sequencer is idle. On acceptance all channels are latched.
  - A strobe arriving while the sequencer is busy is dropped and sets `overrun`.
  - `overrun` clears only on reset.
- FSM states: ARMED, ACTIVE, WAIT.
- ARMED:
  - Each accepted sample updates `prev` = conv(trigger channel). The first sample after entering ARMED only loads `prev` and cannot trigger.
  - Rising trigger: prev < level and cur ≥ level. Falling trigger: prev ≥ level and cur < level.
  - Auto trigger: when `AUTO_TIMEOUT` ≠ 0, a trigger is forced on the accepted sample that brings the ARMED sample counter to `AUTO_TIMEOUT`.
  - On trigger: that sample is written at index 0 and the FSM goes to ACTIVE with index = 1.
  - Non-triggering samples are not written.
- ACTIVE:
  - Each accepted sample is written at the current index for every channel, then index increments.
  - After index 2^SAMPLES_LOG2 − 1 is written (last channel's write issued), the FSM goes to WAIT.
- WAIT:
  - Strobes are ignored; they do not set `overrun`.
  - The first clock edge with `wave_display_idle` = 1 toggles `read_index`, enters ARMED, and clears the prev-valid flag and the auto counter.
- Address: bank = ~read_index; channel = c; index = sample slot.
- Trigger inputs are sampled at the acceptance edge; changes take effect on the next sample.
- Reset during any state aborts the capture immediately. The last partial write is not completed.

## Timing
- Reset values:
  - state ARMED, `read_index` 0, `armed` 1.
  - `write_enable` 0, `write_address` 0, `write_sample` 0, `overrun` 0.
  - index 0, auto counter 0, prev-valid 0.
- All outputs are registered.
- A strobe accepted at edge t that is to be written produces writes at edges t+1 … t+CHANNELS: channel c at edge t+1+c, with `write_enable` high exactly CHANNELS cycles.
- The sequencer is busy for edges t+1 … t+CHANNELS−1. A strobe at edge t+CHANNELS is accepted, so the minimum accepted strobe spacing is CHANNELS cycles.
- WAIT is entered on the edge issuing the final write. The swap can occur at the earliest one edge later.
- `armed` follows the state with no additional latency.

## Test plan
Configuration for all scenarios: CHANNELS=2, IN_WIDTH=16, OUT_WIDTH=8, SAMPLES_LOG2=3, AUTO_TIMEOUT=16.

- **Rising trigger.** Level 0x80, rising. Ch0 = 0xF000, 0xF100, 0x0100, then ramp; ch1 = 0x1234.
  - Required: no writes for the first two samples.
  - Third sample writes 0x81 to address {1,0,000} at t+1 and 0x92 to {1,1,000} at t+2.
  - 8 samples are written, then WAIT.
- **Falling trigger on ch1.** `trig_channel` = 1, `trig_falling` = 1, level 0x40. Ch1 steps 0x4000 → 0x3F00 (bytes 0xC0 → 0xBF).
  - Required: no trigger.
  - With ch1 stepping 0xC100 → 0xBF00 (0x41 → 0x3F), the trigger fires.
- **Auto trigger.** Constant input 0x0000.
  - Required: the 16th accepted sample triggers, and writes of 0x80 follow.
- **Bank swap.** Hold `wave_display_idle` = 0 in WAIT for 20 cycles with strobes present.
  - Required: no writes, `read_index` stays 0, `overrun` stays 0.
  - Raise idle: `read_index` becomes 1 on the next edge and `armed` goes to 1. The next capture uses bank 0.
- **Overrun.** Strobes 1 cycle apart in ACTIVE.
  - Required: the second strobe is dropped, `overrun` goes to 1 and stays 1 until reset, and the index advances by 1 only.
- **Reset mid-capture.** Assert reset after index 3 in ACTIVE.
  - Required: the next cycle shows all outputs at reset values, with `armed` = 1 and `read_index` = 0.
